// File: rtl/mult_pkg.sv
// Shared types and constants for the signed shift-add multiplier datapath.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LOADED = 3'd2,
    S_RUN    = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/mult_datapath_sign_magnitude.sv
// Conditional two's-complement negate: yields |val| at capture, or the
// signed result in the fix-up step when flip_i is set on a non-negative value.
module sign_magnitude #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         flip_i,
  output logic [W-1:0] out_o
);

  always_comb begin
    out_o = val_i;
    if (val_i[W-1] ^ flip_i)
      out_o = -val_i;
  end

endmodule

// File: rtl/mult_datapath.sv
// Responder side of the multiplier handshake: operand capture, signed
// shift-add multiply over WIDTH iterations, and sign fix-up of the product.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load_data,
  input  logic               mult_active,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  output logic               loading_done,
  output logic               mult_done,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);

  state_e        state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          ld_q, md_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    fix_val;
  logic             capture;

  sign_magnitude #(.W(WIDTH)) u_mag_a (
    .val_i  (multiplicand_in),
    .flip_i (1'b0),
    .out_o  (mag_a)
  );

  sign_magnitude #(.W(WIDTH)) u_mag_b (
    .val_i  (multiplier_in),
    .flip_i (1'b0),
    .out_o  (mag_b)
  );

  // acc is a magnitude; gating on |acc_q keeps a zero result positive
  sign_magnitude #(.W(PW)) u_fix (
    .val_i  (acc_q),
    .flip_i (neg_q & (|acc_q)),
    .out_o  (fix_val)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    capture  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_data) capture = 1'b1;
      end
      S_LOAD: state_d = S_LOADED;
      S_LOADED: begin
        if (mult_active) begin
          state_d = S_RUN;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (!load_data) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (load_data) begin
          capture = 1'b1;
        end else if (!mult_active) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        prod_d  = fix_val;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      state_d  = S_LOAD;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      neg_d    = multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      ld_q     <= 1'b0;
      md_q     <= 1'b0;
    end else if (clr) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      ld_q     <= 1'b0;
      md_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      ld_q     <= (state_d == S_LOADED);
      md_q     <= (state_d == S_DONE);
    end
  end

  assign loading_done = ld_q;
  assign mult_done    = md_q;
  assign product      = prod_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_LOADED) ||
                        (state_q == S_RUN);

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: handshake timing, signed products,
// aborts, hold, clear and asynchronous reset.
module tb_mult_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        load_data = 1'b0;
  logic        mult_active = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        loading_done, mult_done, busy;
  logic [15:0] product;

  int n_cmp = 0;
  int n_err = 0;

  // operands the model believes the DUT is multiplying
  int mdl_a = 0, mdl_b = 0;
  int pend_a = 0, pend_b = 0;

  mult_datapath #(.WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .clr             (clr),
    .load_data       (load_data),
    .mult_active     (mult_active),
    .multiplicand_in (a_in),
    .multiplier_in   (b_in),
    .loading_done    (loading_done),
    .mult_done       (mult_done),
    .product         (product),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ld_md_excl", 16'(loading_done & mult_done), 16'h0);
      if (mult_done)
        chk("model_prod", product, 16'(mdl_a * mdl_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input int a, input int b);
    a_in = 8'(a);
    b_in = 8'(b);
    pend_a = a;
    pend_b = b;
    load_data = 1'b1;
    mult_active = 1'b0;
    tick();
    chk("ld_edge1", 16'(loading_done), 16'h0);
    chk("busy_load", 16'(busy), 16'h1);
    tick();
    chk("ld_edge2", 16'(loading_done), 16'h1);
  endtask

  task automatic start_run();
    mdl_a = pend_a;
    mdl_b = pend_b;
    load_data = 1'b0;
    mult_active = 1'b1;
  endtask

  task automatic run_phase(input string nm, input logic [15:0] exp);
    start_run();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("ld_fall", 16'(loading_done), 16'h0);
      if (k < 10) chk("md_early", 16'(mult_done), 16'h0);
    end
    chk("md_lat10", 16'(mult_done), 16'h1);
    chk(nm, product, exp);
    mult_active = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_ld", 16'(loading_done), 16'h0);
    chk("rst_md", 16'(mult_done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_prod", product, 16'h0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    load_ops(5, 3);
    run_phase("p_5x3", 16'h000F);
    load_ops(0, -5);
    run_phase("p_0xm5", 16'h0000);
    load_ops(-128, -128);
    run_phase("p_m128sq", 16'h4000);
    load_ops(-128, 127);
    run_phase("p_m128x127", 16'hC080);
    load_ops(-7, 6);
    run_phase("p_m7x6", 16'hFFD6);

    a_in = 8'd1;
    b_in = 8'd1;
    repeat (3) tick();
    chk("hold_prod", product, 16'hFFD6);
    chk("hold_md", 16'(mult_done), 16'h1);
    load_data = 1'b1;
    pend_a = 1;
    pend_b = 1;
    tick();
    chk("reload_md", 16'(mult_done), 16'h0);
    chk("reload_prod", product, 16'hFFD6);
    tick();
    chk("reload_ld", 16'(loading_done), 16'h1);

    start_run();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ld", 16'(loading_done), 16'h0);
    chk("arst_md", 16'(mult_done), 16'h0);
    chk("arst_prod", product, 16'h0);
    chk("arst_busy", 16'(busy), 16'h0);
    #2 rst = 1'b0;
    mult_active = 1'b0;
    tick();

    load_ops(9, 9);
    start_run();
    repeat (3) tick();
    load_ops(2, 2);
    run_phase("p_abort_2x2", 16'h0004);

    load_ops(3, 3);
    start_run();
    repeat (4) tick();
    mult_active = 1'b0;
    tick();
    chk("drop_busy", 16'(busy), 16'h0);
    chk("drop_md", 16'(mult_done), 16'h0);
    chk("drop_prod", product, 16'h0004);
    repeat (12) tick();
    chk("drop_md_late", 16'(mult_done), 16'h0);

    load_ops(7, 7);
    run_phase("p_7x7", 16'h0031);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_prod", product, 16'h0000);
    chk("clr_md", 16'(mult_done), 16'h0);
    chk("clr_busy", 16'(busy), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
